// File: rtl/td4_execute.sv
// TD4 execute/state stage: registers A/B, output latch, carry flag and PC.
// Optional build macro TD4_HALT_ON_INVALID_EN makes INVALID trap (halted=1) instead of acting as NOP.

package lib_cpu;
  typedef enum logic [3:0] {
    ADD_A_IMM = 4'b0000,
    MOV_A_B   = 4'b0001,
    IN_A      = 4'b0010,
    MOV_A_IMM = 4'b0011,
    MOV_B_A   = 4'b0100,
    ADD_B_IMM = 4'b0101,
    IN_B      = 4'b0110,
    MOV_B_IMM = 4'b0111,
    INVALID   = 4'b1000,
    OUT_B     = 4'b1001,
    OUT_IMM   = 4'b1011,
    JNC_IMM   = 4'b1110,
    JMP_IMM   = 4'b1111
  } OPECODE;
endpackage

module td4_execute
  import lib_cpu::*;
#(
  parameter logic [3:0] RESET_PC  = 4'h0,
  parameter logic [3:0] RESET_OUT = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  OPECODE     opecode,
  input  logic [3:0] imm,
  input  logic [3:0] in_port,
  output logic [3:0] pc,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry,
  output logic       halted
);

  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       carry_q, carry_d;
  logic [3:0] add_src;
  logic [4:0] sum;

`ifdef TD4_HALT_ON_INVALID_EN
  logic halted_q, halted_d;
`endif

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    pc_d    = pc_q + 4'd1;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = 1'b0;
`ifdef TD4_HALT_ON_INVALID_EN
    halted_d = halted_q;
`endif
    // One shared adder; only ADD_B_IMM routes B into it.
    add_src = (opecode == ADD_B_IMM) ? b_q : a_q;
    sum     = {1'b0, add_src} + {1'b0, imm};

    unique case (opecode)
      ADD_A_IMM: begin a_d = sum[3:0]; carry_d = sum[4]; end
      ADD_B_IMM: begin b_d = sum[3:0]; carry_d = sum[4]; end
      MOV_A_IMM: a_d = imm;
      MOV_B_IMM: b_d = imm;
      MOV_A_B:   a_d = b_q;
      MOV_B_A:   b_d = a_q;
      IN_A:      a_d = in_port;
      IN_B:      b_d = in_port;
      OUT_B:     out_d = b_q;
      OUT_IMM:   out_d = imm;
      JMP_IMM:   pc_d = imm;
      JNC_IMM:   if (!carry_q) pc_d = imm;
      default: begin
`ifdef TD4_HALT_ON_INVALID_EN
        pc_d     = pc_q;
        carry_d  = carry_q;
        halted_d = 1'b1;
`endif
      end
    endcase

`ifdef TD4_HALT_ON_INVALID_EN
    // A trapped core is frozen until reset, whatever the decoder presents.
    if (halted_q) begin
      pc_d     = pc_q;
      a_d      = a_q;
      b_d      = b_q;
      out_d    = out_q;
      carry_d  = carry_q;
      halted_d = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      out_q    <= RESET_OUT;
      carry_q  <= 1'b0;
`ifdef TD4_HALT_ON_INVALID_EN
      halted_q <= 1'b0;
`endif
    end else if (en) begin
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
`ifdef TD4_HALT_ON_INVALID_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = carry_q;
`ifdef TD4_HALT_ON_INVALID_EN
  assign halted   = halted_q;
`else
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_td4_execute.sv
// Self-checking bench for td4_execute: directed scenarios plus randomized instruction streams
// compared against an arithmetic model of the architectural state.

module tb_td4_execute;
  import lib_cpu::*;

  logic       clk = 1'b0;
  logic       rst, en;
  OPECODE     opecode;
  logic [3:0] imm, in_port;
  logic [3:0] pc, out_port, reg_a, reg_b;
  logic       carry, halted;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Reference model state as plain integers.
  int m_pc, m_a, m_b, m_out, m_c, m_h;

  logic [17:0] dut_state;
  assign dut_state = {pc, reg_a, reg_b, out_port, carry, halted};

  td4_execute #(.RESET_PC(4'h0), .RESET_OUT(4'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .opecode(opecode), .imm(imm), .in_port(in_port),
    .pc(pc), .out_port(out_port), .reg_a(reg_a), .reg_b(reg_b), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model_state();
    return {4'(m_pc), 4'(m_a), 4'(m_b), 4'(m_out), 1'(m_c), 1'(m_h)};
  endfunction

  task automatic model_step(input logic r, input logic e, input OPECODE op,
                            input int i, input int inp);
    int npc, nc, s;
    if (r) begin
      m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_h = 0;
    end else if (e && m_h == 0) begin
      npc = (m_pc + 1) % 16;
      nc  = 0;
      case (op)
        ADD_A_IMM: begin s = m_a + i; m_a = s % 16; nc = s / 16; end
        ADD_B_IMM: begin s = m_b + i; m_b = s % 16; nc = s / 16; end
        MOV_A_IMM: m_a = i;
        MOV_B_IMM: m_b = i;
        MOV_A_B:   m_a = m_b;
        MOV_B_A:   m_b = m_a;
        IN_A:      m_a = inp;
        IN_B:      m_b = inp;
        OUT_B:     m_out = m_b;
        OUT_IMM:   m_out = i;
        JMP_IMM:   npc = i;
        JNC_IMM:   if (m_c == 0) npc = i;
        default: begin
`ifdef TD4_HALT_ON_INVALID_EN
          m_h = 1; npc = m_pc; nc = m_c;
`endif
        end
      endcase
      m_pc = npc;
      m_c  = nc;
    end
  endtask

  task automatic cycle(input logic r, input logic e, input OPECODE op,
                       input logic [3:0] i, input logic [3:0] inp);
    rst = r; en = e; opecode = op; imm = i; in_port = inp;
    @(posedge clk);
    #1;
    model_step(r, e, op, int'(i), int'(inp));
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, JMP_IMM, 4'h9, 4'h0);
    cycle(1'b1, 1'b1, JMP_IMM, 4'h9, 4'h0);
    tests_run++;
    if (dut_state !== 18'h0) begin
      fail_cnt++;
      $display("FAIL reset_state: got %h expected %h", dut_state, 18'h0);
    end
    cycle(1'b0, 1'b0, JMP_IMM, 4'h9, 4'h0);
    tests_run++;
    if (dut_state !== model_state() || pc !== 4'h0) begin
      fail_cnt++;
      $display("FAIL reset_release: got %h expected %h", dut_state, model_state());
    end
  endtask

  task automatic test_add_carry();
    cycle(1'b0, 1'b1, MOV_A_IMM, 4'hE, 4'h0);
    cycle(1'b0, 1'b1, ADD_A_IMM, 4'h3, 4'h0);
    tests_run++;
    if (reg_a !== 4'h1 || carry !== 1'b1 || pc !== 4'h2) begin
      fail_cnt++;
      $display("FAIL add_wrap: got a=%h c=%b pc=%h expected a=1 c=1 pc=2", reg_a, carry, pc);
    end
    cycle(1'b0, 1'b1, MOV_B_IMM, 4'h5, 4'h0);
    tests_run++;
    if (reg_b !== 4'h5 || carry !== 1'b0 || dut_state !== model_state()) begin
      fail_cnt++;
      $display("FAIL mov_clears_carry: got %h expected %h", dut_state, model_state());
    end
  endtask

  task automatic test_jnc();
    logic [3:0] pc_before;
    cycle(1'b0, 1'b1, MOV_A_IMM, 4'hF, 4'h0);
    cycle(1'b0, 1'b1, ADD_A_IMM, 4'h1, 4'h0);
    pc_before = pc;
    cycle(1'b0, 1'b1, JNC_IMM, 4'hA, 4'h0);
    tests_run++;
    if (pc !== pc_before + 4'd1 || carry !== 1'b0) begin
      fail_cnt++;
      $display("FAIL jnc_not_taken: got pc=%h c=%b expected pc=%h c=0", pc, carry, pc_before + 4'd1);
    end
    cycle(1'b0, 1'b1, JNC_IMM, 4'hA, 4'h0);
    tests_run++;
    if (pc !== 4'hA || dut_state !== model_state()) begin
      fail_cnt++;
      $display("FAIL jnc_taken: got %h expected %h", dut_state, model_state());
    end
  endtask

  task automatic test_enable_io();
    logic [17:0] snap;
    snap = dut_state;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, IN_B, 4'h0, 4'h6);
      tests_run++;
      if (dut_state !== snap) begin
        fail_cnt++;
        $display("FAIL enable_hold: got %h expected %h", dut_state, snap);
      end
    end
    cycle(1'b0, 1'b1, IN_B, 4'h0, 4'h6);
    tests_run++;
    if (reg_b !== 4'h6 || dut_state !== model_state()) begin
      fail_cnt++;
      $display("FAIL in_b: got %h expected %h", dut_state, model_state());
    end
    cycle(1'b0, 1'b1, OUT_B, 4'h0, 4'h9);
    tests_run++;
    if (out_port !== 4'h6) begin
      fail_cnt++;
      $display("FAIL out_b: got %h expected 6", out_port);
    end
    cycle(1'b0, 1'b1, OUT_IMM, 4'h3, 4'h9);
    tests_run++;
    if (out_port !== 4'h3 || dut_state !== model_state()) begin
      fail_cnt++;
      $display("FAIL out_imm: got %h expected %h", dut_state, model_state());
    end
  endtask

  task automatic test_pc_wrap();
    cycle(1'b0, 1'b1, JMP_IMM, 4'hF, 4'h0);
    tests_run++;
    if (pc !== 4'hF) begin
      fail_cnt++;
      $display("FAIL jmp_f: got %h expected f", pc);
    end
    cycle(1'b0, 1'b1, MOV_A_IMM, 4'h7, 4'h0);
    tests_run++;
    if (pc !== 4'h0 || reg_a !== 4'h7) begin
      fail_cnt++;
      $display("FAIL pc_wrap: got pc=%h a=%h expected pc=0 a=7", pc, reg_a);
    end
  endtask

  task automatic test_invalid();
    logic [17:0] snap;
    cycle(1'b0, 1'b1, JMP_IMM, 4'h2, 4'h0);
    cycle(1'b0, 1'b1, MOV_A_IMM, 4'hF, 4'h0);
    cycle(1'b0, 1'b1, ADD_A_IMM, 4'h1, 4'h0);
    cycle(1'b0, 1'b1, INVALID, 4'h5, 4'h0);
`ifdef TD4_HALT_ON_INVALID_EN
    tests_run++;
    if (halted !== 1'b1 || pc !== 4'h4 || carry !== 1'b1) begin
      fail_cnt++;
      $display("FAIL invalid_halt: got h=%b pc=%h c=%b expected h=1 pc=4 c=1", halted, pc, carry);
    end
    snap = dut_state;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, (k % 2 == 0) ? JMP_IMM : ADD_B_IMM, 4'($urandom), 4'($urandom));
      tests_run++;
      if (dut_state !== snap) begin
        fail_cnt++;
        $display("FAIL halted_frozen: got %h expected %h", dut_state, snap);
      end
    end
`else
    snap = model_state();
    tests_run++;
    if (pc !== 4'h5 || carry !== 1'b0 || halted !== 1'b0 || dut_state !== snap) begin
      fail_cnt++;
      $display("FAIL invalid_nop: got %h expected %h", dut_state, snap);
    end
`endif
  endtask

  task automatic test_reset_midrun();
    cycle(1'b0, 1'b1, MOV_B_IMM, 4'hC, 4'h0);
    cycle(1'b0, 1'b1, OUT_IMM, 4'hD, 4'h0);
    cycle(1'b1, 1'b1, ADD_A_IMM, 4'h5, 4'h0);
    tests_run++;
    if (dut_state !== 18'h0) begin
      fail_cnt++;
      $display("FAIL reset_midrun: got %h expected %h", dut_state, 18'h0);
    end
  endtask

  task automatic test_back_to_back();
    OPECODE ops [13] = '{ADD_A_IMM, ADD_B_IMM, MOV_A_IMM, MOV_B_IMM, MOV_A_B, MOV_B_A,
                         IN_A, IN_B, OUT_B, OUT_IMM, JMP_IMM, JNC_IMM, INVALID};
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            ops[$urandom_range(0, 12)], 4'($urandom), 4'($urandom));
      tests_run++;
      if (dut_state !== model_state()) begin
        fail_cnt++;
        $display("FAIL random_step %0d: got %h expected %h", k, dut_state, model_state());
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; opecode = JMP_IMM; imm = 4'h0; in_port = 4'h0;
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_h = 0;
    test_reset();
    test_add_carry();
    test_jnc();
    test_enable_io();
    test_pc_wrap();
    test_invalid();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/td4_execute.md
Name: td4_execute

Overview:
- Execute/state stage of the TD4 CPU, directly downstream of the instruction decoder.
- Consumes the decoded opcode (`OPECODE` enum from `lib_cpu`) and the 4-bit immediate.
- Owns the architectural state: registers A and B, the output latch, the carry flag and the program counter.
- `pc` feeds the program ROM, whose byte drives the decoder. One instruction retires per enabled clock.

Parameters:
- RESET_PC, 4'h0: PC value loaded on reset.
- RESET_OUT, 4'h0: output latch value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable from the clock divider/single-step logic; state holds when low.
- opecode  input  OPECODE  decoded operation from the decoder (combinational, same cycle).
- imm  input  4  immediate field from the decoder.
- in_port  input  4  external input switches; sampled only by IN_A/IN_B.
- pc  output  4  program counter; the ROM address.
- out_port  output  4  registered output latch (LEDs).
- reg_a  output  4  register A.
- reg_b  output  4  register B.
- carry  output  1  carry flag.
- halted  output  1  trap status (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge, regardless of en): pc=RESET_PC, reg_a=0, reg_b=0, out_port=RESET_OUT, carry=0, halted=0.
- Reset mid-run overrides any instruction presented in the same cycle.
- en=0: all state holds. No PC advance, no flag change.
- en=1, single cycle per instruction. The new state is visible after the edge.
- Adder: one shared 5-bit sum {c,s} = {1'b0,x} + {1'b0,imm}; s is written back, c is the next carry. Wrap-around mod 16 is intentional (e.g. 4'hF+1 gives 0 with carry=1).
- Carry rule: only ADD_A_IMM and ADD_B_IMM write the adder carry. Every other executed instruction clears carry to 0, including JNC and the jumps.
- Per-opcode next-state rules:
  - ADD_A_IMM: A=A+imm.
  - ADD_B_IMM: B=B+imm.
  - MOV_A_IMM: A=imm.
  - MOV_B_IMM: B=imm.
  - MOV_A_B: A=B.
  - MOV_B_A: B=A.
  - IN_A: A=in_port.
  - IN_B: B=in_port.
  - OUT_B: out_port=B.
  - OUT_IMM: out_port=imm.
  - JMP_IMM: pc=imm.
  - JNC_IMM: pc=imm if carry==0 (the pre-edge carry), else pc=pc+1.
- PC: pc=pc+1 mod 16 for every non-taken-jump instruction. 4'hF wraps to 4'h0.
- Registers not named by an opcode hold.
- INVALID: treated as NOP. pc+1, carry cleared, all other state holds (macro off).
- Single next-state always_comb selected by a unique case on opecode. A single always_ff holds the registers with synchronous reset priority, then en.

Optional Feature:
- Macro: TD4_HALT_ON_INVALID_EN.
- Defined:
  - INVALID with en=1 sets halted=1. pc, A, B, out_port and carry hold (pc stays at the offending address).
  - While halted=1 the block ignores en and opcodes; state is frozen.
  - Only rst clears halted.
- Not defined: halted is tied to 0 and INVALID behaves as NOP per Behaviour.

Test Plan:
- Reset: drive rst=1 for 2 cycles with en=1 and opecode=JMP_IMM, imm=4'h9. Required: pc=0, A=B=0, out_port=0, carry=0, halted=0 after release.
- Add and carry: MOV_A_IMM 4'hE, then ADD_A_IMM 4'h3. Required: A=4'h1, carry=1, pc=2. Then MOV_B_IMM 4'h5. Required: carry=0, B=5.
- JNC: with carry=1, JNC_IMM 4'hA. Required: pc advances to +1, carry=0. Repeat with carry=0. Required: pc=4'hA.
- Enable/IO: in_port=4'h6, IN_B with en=0 for 3 cycles. Required: B and pc unchanged. Then en=1. Required: B=6. Then OUT_B. Required: out_port=6. Then OUT_IMM 4'h3. Required: out_port=3.
- PC wrap: JMP_IMM 4'hF, then any MOV. Required: pc=4'h0.
- INVALID at pc=4'h4:
  - Macro off: pc=5, carry=0.
  - Macro on: halted=1, pc stays 4, and 5 further enabled cycles change nothing until rst.
